hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
// Parametrised Tuse/Tnew hazard unit for the pipelined MIPS core. Tracks in-flight register writers
// in the STAGES pipeline stages after D (E, M, W by default) and counts down each writer's Tnew.
// Compares them with the Tuse of the instruction in D and produces the D-stage stall and forwarding selects.
// Generalises the per-instruction Tuse/Tnew decode to any pipeline depth, with freeze and D-flush.
// PARAMETERS
// STAGES   3  tracked stages after D; entry 1 = E ... entry STAGES = last writer stage
// REG_W    5  register address width
// TNEW_W   3  Tnew/Tuse field width; all-ones Tuse = TUSE_NONE (operand not read)
// PORTS
// clk       in   1             clock, rising edge
// reset     in   1             asynchronous, active-high; clears all entries
// freeze    in   1             multi-cycle unit busy: hold all entries, force stall
// flush_d   in   1             kill the instruction in D; it is not inserted
// d_valid   in   1             D holds a real instruction
// d_rs      in   REG_W         D source 1 address
// d_rt      in   REG_W         D source 2 address
// d_tuse_rs in   TNEW_W        cycles until rs is needed (0 = in D)
// d_tuse_rt in   TNEW_W        cycles until rt is needed
// d_dst     in   REG_W         D destination address
// d_we      in   1             D writes d_dst
// d_tnew    in   TNEW_W        cycles after entering E until the result is in the pipeline register
// stall     out  1             hold PC/D, insert bubble into E
// fwd_rs    out  $clog2(STAGES+1)  0 = register file; k = forward from entry k
// fwd_rt    out  $clog2(STAGES+1)  same for rt
// busy      out  1             any valid entry with tnew > 0
// BEHAVIOUR
// - Entry k = {valid, dst, tnew}. Reset (async): all valid=0, so stall=0, fwd_*=0, busy=0 immediately.
// - Match(k, src): valid_k & dst_k == src & src != 0. Register 0 never matches.
// - Hazard(src, tuse): tuse != TUSE_NONE and the youngest match (lowest k) has tnew_k > tuse.
//   Only the youngest match is considered; older writers to the same register are shadowed.
// - stall = freeze | (d_valid & ~flush_d & (Hazard(rs) | Hazard(rt))). Combinational, same cycle.
// - fwd_x = k if the youngest match k has tnew_k == 0, else 0. Computed whether or not stall is asserted.
//   The downstream stages resolve tnew > 0 non-stalling cases with their own forwarding.
// - Clock edge, freeze=1: no entry changes. freeze dominates flush_d.
// - Clock edge, freeze=0: entry k+1 <= entry k with tnew-1 (saturating at 0).
//   Entry 1 <= {d_valid & d_we & ~flush_d & ~stall, d_dst, d_tnew}; otherwise a bubble (valid=0).
//   Entry STAGES retires.
// - d_we with d_dst==0 may be inserted, but it never matches.
// - d_tnew==0 (for example jal/jalr PC+8): forwardable from entry 1 on the next cycle.
// - Latency: zero-cycle decision; a stall clears once the blocking entry's tnew has decremented to <= tuse.
// - busy is combinational OR over entries of (valid & tnew != 0).
// STRUCTURE
// - Shared package (hazard_pkg): TNEW_W, TUSE_NONE, TNEW_ALU=1, TNEW_DM=2, TNEW_PC=0 constants.
//   The package also holds the entry struct typedef {valid, dst, tnew}.
// - One sub-module is natural: hazard_src_check (one instance per source operand), generate-looped over
//   STAGES, priority-encodes the youngest match and outputs {hazard, fwd}.
// - Top: entry shift register, bubble/freeze/flush control, OR of busy terms.
// TESTING (STAGES=3)
// - lw $1 (tnew 2), then addu rs=$1 (tuse 1) -> cycle1 stall=1.
//   cycle2 stall=0, fwd_rs=0 (entry2 tnew=1); cycle3 entry3 tnew=0.
// - addu $2 (tnew 1), then beq rs=$2 (tuse 0) -> stall for 1 cycle, then fwd_rs=2, stall=0.
// - jal (dst $31, tnew 0), then jr $31 (tuse 0) -> no stall, fwd_rs=1.
// - Writes $3 twice (older tnew 0 in entry2, younger tnew 2 in entry1); reader tuse 1 -> stall=1.
//   The younger writer shadows the older.
// - Writer to $0 (tnew 2), then reader of $0 -> stall=0, fwd=0.
//   flush_d on a lw -> entry1 stays invalid.
// - freeze for 3 cycles with lw in entry1 -> stall=1 and entries unchanged.
//   Assert reset mid-freeze -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and types for the Tuse/Tnew hazard scoreboard.
//   REG_W / TNEW_W : default register-address and Tnew/Tuse field widths
//   TUSE_NONE      : Tuse code meaning "operand not read"
//   TNEW_*         : Tnew values of the common writer classes
//   entry_t        : one tracked writer {valid, dst, tnew} at default widths
package hazard_pkg;

    localparam int REG_W  = 5;
    localparam int TNEW_W = 3;

    localparam logic [TNEW_W-1:0] TUSE_NONE = 3'b111;
    localparam logic [TNEW_W-1:0] TNEW_ALU  = 3'd1;
    localparam logic [TNEW_W-1:0] TNEW_DM   = 3'd2;
    localparam logic [TNEW_W-1:0] TNEW_PC   = 3'd0;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  dst;
        logic [TNEW_W-1:0] tnew;
    } entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage request / hazard-decision bundle of the scoreboard.
//   master : drives the D-stage instruction fields and pipeline controls
//   slave  : the scoreboard; returns stall, fwd_rs, fwd_rt, busy
interface hazard_scoreboard_if #(
    parameter int STAGES = 3,
    parameter int REG_W  = 5,
    parameter int TNEW_W = 3,
    parameter int FWD_W  = $clog2(STAGES + 1)
);

    logic              freeze;
    logic              flush_d;
    logic              d_valid;
    logic [REG_W-1:0]  d_rs;
    logic [REG_W-1:0]  d_rt;
    logic [TNEW_W-1:0] d_tuse_rs;
    logic [TNEW_W-1:0] d_tuse_rt;
    logic [REG_W-1:0]  d_dst;
    logic              d_we;
    logic [TNEW_W-1:0] d_tnew;
    logic              stall;
    logic [FWD_W-1:0]  fwd_rs;
    logic [FWD_W-1:0]  fwd_rt;
    logic              busy;

    modport master (
        output freeze, flush_d, d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
               d_dst, d_we, d_tnew,
        input  stall, fwd_rs, fwd_rt, busy
    );

    modport slave (
        input  freeze, flush_d, d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt,
               d_dst, d_we, d_tnew,
        output stall, fwd_rs, fwd_rt, busy
    );

endinterface

// File: rtl/hazard_src_check.sv
// Per-operand hazard check against the tracked writer entries.
//   ent_valid/ent_dst/ent_tnew : entries, index 0 = entry 1 (youngest)
//   src, tuse                  : operand address and its Tuse
//   hazard                     : youngest matching writer is not ready in time
//   fwd                        : k when youngest match is entry k with tnew 0, else 0
module hazard_src_check
    import hazard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REG_W  = hazard_pkg::REG_W,
    parameter int TNEW_W = hazard_pkg::TNEW_W,
    parameter int FWD_W  = $clog2(STAGES + 1)
) (
    input  logic [STAGES-1:0]             ent_valid,
    input  logic [STAGES-1:0][REG_W-1:0]  ent_dst,
    input  logic [STAGES-1:0][TNEW_W-1:0] ent_tnew,
    input  logic [REG_W-1:0]              src,
    input  logic [TNEW_W-1:0]             tuse,
    output logic                          hazard,
    output logic [FWD_W-1:0]              fwd
);

    localparam logic [TNEW_W-1:0] TUSE_NONE_S = {TNEW_W{1'b1}};

    logic [STAGES-1:0] match_s;
    logic              hit_s;
    logic [TNEW_W-1:0] hit_tnew_s;
    logic [FWD_W-1:0]  hit_idx_s;

    // Register 0 is hard-wired, so a writer of $0 never matches.
    for (genvar k = 0; k < STAGES; k++) begin : g_match
        assign match_s[k] = ent_valid[k] & (ent_dst[k] == src) & (src != {REG_W{1'b0}});
    end

    // Priority-encode the youngest match: scanning oldest to youngest, the last hit wins.
    always_comb begin
        hit_s      = 1'b0;
        hit_tnew_s = {TNEW_W{1'b0}};
        hit_idx_s  = {FWD_W{1'b0}};
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (match_s[k]) begin
                hit_s      = 1'b1;
                hit_tnew_s = ent_tnew[k];
                hit_idx_s  = FWD_W'(k + 1);
            end else begin
                hit_s      = hit_s;
            end
        end
    end

    // Hazard and forward select from the youngest match only; older writers are shadowed.
    always_comb begin
        hazard = 1'b0;
        fwd    = {FWD_W{1'b0}};
        if (hit_s) begin
            hazard = (tuse != TUSE_NONE_S) && (hit_tnew_s > tuse);
            fwd    = (hit_tnew_s == {TNEW_W{1'b0}}) ? hit_idx_s : {FWD_W{1'b0}};
        end else begin
            hazard = 1'b0;
            fwd    = {FWD_W{1'b0}};
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard for the pipelined MIPS core.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   hif        : slave side of hazard_scoreboard_if
//                inputs  freeze, flush_d, d_valid, d_rs, d_rt, d_tuse_rs,
//                        d_tuse_rt, d_dst, d_we, d_tnew
//                outputs stall, fwd_rs, fwd_rt, busy (combinational)
// Entry 1 holds the writer in E; each edge shifts writers one stage older
// while counting their Tnew down to 0; the last entry retires.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REG_W  = hazard_pkg::REG_W,
    parameter int TNEW_W = hazard_pkg::TNEW_W
) (
    input  logic          clk,
    input  logic          reset,
    hazard_scoreboard_if.slave hif
);

    localparam int FWD_W = $clog2(STAGES + 1);

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  dst;
        logic [TNEW_W-1:0] tnew;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, dst: {REG_W{1'b0}}, tnew: {TNEW_W{1'b0}}};

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        logic [TNEW_W-1:0] r;
        if (t == {TNEW_W{1'b0}}) begin
            r = {TNEW_W{1'b0}};
        end else begin
            r = t - TNEW_W'(1'b1);
        end
        return r;
    endfunction

    slot_t [STAGES-1:0]             ent_r;
    slot_t                          ins_s;
    logic  [STAGES-1:0]             ent_valid_s;
    logic  [STAGES-1:0][REG_W-1:0]  ent_dst_s;
    logic  [STAGES-1:0][TNEW_W-1:0] ent_tnew_s;
    logic                           haz_rs_s;
    logic                           haz_rt_s;
    logic  [FWD_W-1:0]              fwd_rs_s;
    logic  [FWD_W-1:0]              fwd_rt_s;
    logic                           stall_s;
    logic                           busy_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_unpack
        assign ent_valid_s[k] = ent_r[k].valid;
        assign ent_dst_s[k]   = ent_r[k].dst;
        assign ent_tnew_s[k]  = ent_r[k].tnew;
    end

    hazard_src_check #(
        .STAGES (STAGES), .REG_W (REG_W), .TNEW_W (TNEW_W), .FWD_W (FWD_W)
    ) u_chk_rs (
        .ent_valid (ent_valid_s), .ent_dst (ent_dst_s), .ent_tnew (ent_tnew_s),
        .src (hif.d_rs), .tuse (hif.d_tuse_rs), .hazard (haz_rs_s), .fwd (fwd_rs_s)
    );

    hazard_src_check #(
        .STAGES (STAGES), .REG_W (REG_W), .TNEW_W (TNEW_W), .FWD_W (FWD_W)
    ) u_chk_rt (
        .ent_valid (ent_valid_s), .ent_dst (ent_dst_s), .ent_tnew (ent_tnew_s),
        .src (hif.d_rt), .tuse (hif.d_tuse_rt), .hazard (haz_rt_s), .fwd (fwd_rt_s)
    );

    // Stall decision; held low while reset is asserted so the pipe sees all-quiet outputs.
    always_comb begin
        stall_s = 1'b0;
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            stall_s = hif.freeze |
                      (hif.d_valid & ~hif.flush_d & (haz_rs_s | haz_rt_s));
        end
    end

    // Entry 1 candidate: a real, unflushed, unstalled writer, else a bubble.
    always_comb begin
        ins_s = SLOT_EMPTY;
        if (hif.d_valid && hif.d_we && !hif.flush_d && !stall_s) begin
            ins_s = '{valid: 1'b1, dst: hif.d_dst, tnew: hif.d_tnew};
        end else begin
            ins_s = SLOT_EMPTY;
        end
    end

    // Any writer whose result is not yet in a pipeline register.
    always_comb begin
        busy_s = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            busy_s = busy_s | (ent_r[k].valid & (ent_r[k].tnew != {TNEW_W{1'b0}}));
        end
    end

    // Writer shift register; freeze holds every entry (it also dominates flush_d).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_r <= {STAGES{SLOT_EMPTY}};
        end else if (!hif.freeze) begin
            ent_r[0] <= ins_s;
            for (int k = 1; k < STAGES; k++) begin
                ent_r[k].valid <= ent_r[k-1].valid;
                ent_r[k].dst   <= ent_r[k-1].dst;
                ent_r[k].tnew  <= sat_dec(ent_r[k-1].tnew);
            end
        end
    end

    assign hif.stall  = stall_s;
    assign hif.fwd_rs = fwd_rs_s;
    assign hif.fwd_rt = fwd_rt_s;
    assign hif.busy   = busy_s;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (STAGES = 3).
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.STAGES(3), .REG_W(5), .TNEW_W(3)) hif ();

    hazard_scoreboard #(.STAGES(3), .REG_W(5), .TNEW_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    task automatic set_d(input logic valid, input logic [4:0] rs, input logic [2:0] tuse_rs,
                         input logic [4:0] rt, input logic [2:0] tuse_rt,
                         input logic [4:0] dst, input logic we, input logic [2:0] tnew);
        hif.d_valid   = valid;
        hif.d_rs      = rs;
        hif.d_tuse_rs = tuse_rs;
        hif.d_rt      = rt;
        hif.d_tuse_rt = tuse_rt;
        hif.d_dst     = dst;
        hif.d_we      = we;
        hif.d_tnew    = tnew;
    endtask

    task automatic idle();
        hif.freeze  = 1'b0;
        hif.flush_d = 1'b0;
        set_d(1'b0, 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 1'b0, TNEW_PC);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    task automatic check(input string tag, input logic exp_stall, input logic [1:0] exp_fwd_rs,
                         input logic [1:0] exp_fwd_rt, input logic exp_busy);
        #1;
        vectors++;
        assert (hif.stall === exp_stall) else begin
            miscompares++;
            $error("FAIL %s stall: observed %0b expected %0b", tag, hif.stall, exp_stall);
        end
        vectors++;
        assert (hif.fwd_rs === exp_fwd_rs) else begin
            miscompares++;
            $error("FAIL %s fwd_rs: observed %0d expected %0d", tag, hif.fwd_rs, exp_fwd_rs);
        end
        vectors++;
        assert (hif.fwd_rt === exp_fwd_rt) else begin
            miscompares++;
            $error("FAIL %s fwd_rt: observed %0d expected %0d", tag, hif.fwd_rt, exp_fwd_rt);
        end
        vectors++;
        assert (hif.busy === exp_busy) else begin
            miscompares++;
            $error("FAIL %s busy: observed %0b expected %0b", tag, hif.busy, exp_busy);
        end
    endtask

    initial begin
        idle();
        #1 reset = 1'b1;
        check("reset", 1'b0, 2'd0, 2'd0, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        check("after_reset", 1'b0, 2'd0, 2'd0, 1'b0);

        // lw $1 (tnew 2) then addu rs=$1 (tuse 1)
        set_d(1'b1, 5'd0, 3'd1, 5'd0, TUSE_NONE, 5'd1, 1'b1, TNEW_DM);
        check("lw1_issue", 1'b0, 2'd0, 2'd0, 1'b0);
        tick();
        set_d(1'b1, 5'd1, 3'd1, 5'd0, 3'd1, 5'd4, 1'b1, TNEW_ALU);
        check("lw1_use_c1", 1'b1, 2'd0, 2'd0, 1'b1);
        tick();
        check("lw1_use_c2", 1'b0, 2'd0, 2'd0, 1'b1);
        tick();
        // $1 now in entry 3 with tnew 0; $4 in entry 1 with tnew 1 still blocks rt
        set_d(1'b1, 5'd1, 3'd0, 5'd4, 3'd0, 5'd0, 1'b0, TNEW_PC);
        check("lw1_fwd3_stall", 1'b1, 2'd3, 2'd0, 1'b1);
        drain();
        check("drained1", 1'b0, 2'd0, 2'd0, 1'b0);

        // addu $2 (tnew 1) then beq $2,$2 (tuse 0)
        set_d(1'b1, 5'd0, 3'd1, 5'd0, 3'd1, 5'd2, 1'b1, TNEW_ALU);
        check("addu2_issue", 1'b0, 2'd0, 2'd0, 1'b0);
        tick();
        set_d(1'b1, 5'd2, 3'd0, 5'd2, 3'd0, 5'd0, 1'b0, TNEW_PC);
        check("beq_stall", 1'b1, 2'd0, 2'd0, 1'b1);
        tick();
        check("beq_fwd2", 1'b0, 2'd2, 2'd2, 1'b0);
        drain();

        // jal ($31, tnew 0) then jr $31
        set_d(1'b1, 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd31, 1'b1, TNEW_PC);
        tick();
        set_d(1'b1, 5'd31, 3'd0, 5'd0, TUSE_NONE, 5'd0, 1'b0, TNEW_PC);
        check("jr_fwd1", 1'b0, 2'd1, 2'd0, 1'b0);
        drain();

        // Two writers of $3: younger tnew 2 in entry 1 shadows older tnew 0 in entry 2
        set_d(1'b1, 5'd0, 3'd1, 5'd0, TUSE_NONE, 5'd3, 1'b1, TNEW_ALU);
        tick();
        set_d(1'b1, 5'd0, 3'd1, 5'd0, TUSE_NONE, 5'd3, 1'b1, TNEW_DM);
        check("w3_second", 1'b0, 2'd0, 2'd0, 1'b1);
        tick();
        set_d(1'b1, 5'd3, 3'd1, 5'd3, TUSE_NONE, 5'd0, 1'b0, TNEW_PC);
        check("w3_shadow", 1'b1, 2'd0, 2'd0, 1'b1);
        drain();

        // Writer of $0 never matches
        set_d(1'b1, 5'd0, 3'd1, 5'd0, TUSE_NONE, 5'd0, 1'b1, TNEW_DM);
        tick();
        set_d(1'b1, 5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 1'b0, TNEW_PC);
        check("r0_nomatch", 1'b0, 2'd0, 2'd0, 1'b1);
        drain();

        // Flushed lw $6 is not inserted
        set_d(1'b1, 5'd0, 3'd1, 5'd0, TUSE_NONE, 5'd6, 1'b1, TNEW_DM);
        hif.flush_d = 1'b1;
        check("flush_issue", 1'b0, 2'd0, 2'd0, 1'b0);
        tick();
        hif.flush_d = 1'b0;
        set_d(1'b1, 5'd6, 3'd0, 5'd0, TUSE_NONE, 5'd0, 1'b0, TNEW_PC);
        check("flush_empty", 1'b0, 2'd0, 2'd0, 1'b0);
        drain();

        // Freeze with lw $7 in entry 1
        set_d(1'b1, 5'd0, 3'd1, 5'd0, TUSE_NONE, 5'd7, 1'b1, TNEW_DM);
        tick();
        hif.freeze = 1'b1;
        set_d(1'b1, 5'd7, 3'd2, 5'd0, TUSE_NONE, 5'd0, 1'b0, TNEW_PC);
        check("freeze_c0", 1'b1, 2'd0, 2'd0, 1'b1);
        tick();
        check("freeze_c1", 1'b1, 2'd0, 2'd0, 1'b1);
        tick();
        check("freeze_c2", 1'b1, 2'd0, 2'd0, 1'b1);
        tick();
        check("freeze_c3", 1'b1, 2'd0, 2'd0, 1'b1);
        // Entry 1 must still hold $7 with tnew 2: tuse 1 stalls
        hif.freeze = 1'b0;
        set_d(1'b1, 5'd7, 3'd1, 5'd0, TUSE_NONE, 5'd0, 1'b0, TNEW_PC);
        check("freeze_held", 1'b1, 2'd0, 2'd0, 1'b1);
        tick();
        check("freeze_moved", 1'b0, 2'd0, 2'd0, 1'b1);
        hif.freeze = 1'b1;
        check("refreeze", 1'b1, 2'd0, 2'd0, 1'b1);
        reset = 1'b1;
        check("reset_mid_freeze", 1'b0, 2'd0, 2'd0, 1'b0);
        tick();
        reset = 1'b0;
        idle();
        check("post_reset", 1'b0, 2'd0, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
